debounce_bank: RTL

Multi-channel switch/button debouncer with a shared sample prescaler, per-channel stability counters, and press-and-hold detection with auto-repeat. It sits between raw board inputs (buttons, DIP switches, encoder contacts) and user logic. It replaces per-signal single-channel debounce instances with one bank. Every output is synchronous to `clk` and is either a level or a one-clock pulse.

---
 rtl/debounce_bank.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer with a shared sample
// prescaler, per-channel stability counters, and press-and-hold detection
// with auto-repeat. All outputs are registered; pulses are one clock wide
// and only appear on the clock after a sample tick.
module debounce_bank #(
  parameter int N          = 4,
  parameter int D          = 16,
  parameter int L          = 8,
  parameter int H          = 64,
  parameter int R          = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic         tick,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] hold,
  output logic [N-1:0] rpt
);

  localparam int SC_W = $clog2(L);
  localparam int HC_W = $clog2(H + 1);
  localparam int RC_W = (R > 1) ? $clog2(R) : 1;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(L - 1);
  localparam logic [HC_W-1:0] HC_SAT  = HC_W'(H);
  localparam logic [HC_W-1:0] HC_PRE  = HC_W'(H - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(R - 1);

  logic [N-1:0]    sync1_q, sync2_q;
  logic [D-1:0]    ctr_q, ctr_d;
  logic            tick_q, tick_d;
  logic [N-1:0]    db_q, db_d;
  logic [N-1:0]    rise_q, rise_d;
  logic [N-1:0]    fall_q, fall_d;
  logic [N-1:0]    hold_q, hold_d;
  logic [N-1:0]    rpt_q, rpt_d;
  logic [SC_W-1:0] sc_q [N];
  logic [SC_W-1:0] sc_d [N];
  logic [HC_W-1:0] hc_q [N];
  logic [HC_W-1:0] hc_d [N];
  logic [RC_W-1:0] rc_q [N];
  logic [RC_W-1:0] rc_d [N];
  logic [N-1:0]    s;

  // Synchronised inputs, optionally inverted so every output stays active-high.
  assign s = sync2_q ^ {N{ACTIVE_LOW}};

  // Free-running prescaler; tick is registered one clock after the wrap value.
  always_comb begin
    ctr_d  = ctr_q + D'(1);
    tick_d = (ctr_q == '1);
  end

  // Per-channel debounce and hold/repeat; state only moves on a tick cycle.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    hold_d = '0;
    rpt_d  = '0;
    for (int i = 0; i < N; i++) begin
      sc_d[i] = sc_q[i];
      hc_d[i] = hc_q[i];
      rc_d[i] = rc_q[i];
      if (tick_q) begin
        if (s[i] == db_q[i]) begin
          sc_d[i] = '0;
        end else if (sc_q[i] == SC_LAST) begin
          db_d[i]   = ~db_q[i];
          sc_d[i]   = '0;
          rise_d[i] = ~db_q[i];
          fall_d[i] = db_q[i];
        end else begin
          sc_d[i] = sc_q[i] + SC_W'(1);
        end
        // Hold progress only counts ticks where the level was and stays high;
        // the rising tick itself and a falling tick both leave it at zero.
        if (db_q[i] && db_d[i]) begin
          if (hc_q[i] != HC_SAT) begin
            hc_d[i] = hc_q[i] + HC_W'(1);
            if (hc_q[i] == HC_PRE) begin
              hold_d[i] = 1'b1;
              rpt_d[i]  = 1'b1;
              rc_d[i]   = '0;
            end
          end else if (rc_q[i] == RC_LAST) begin
            rpt_d[i] = 1'b1;
            rc_d[i]  = '0;
          end else begin
            rc_d[i] = rc_q[i] + RC_W'(1);
          end
        end else begin
          hc_d[i] = '0;
          rc_d[i] = '0;
        end
      end
    end
  end

  // State registers; reset discards any debounce or hold progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ctr_q   <= '0;
      tick_q  <= 1'b0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      hold_q  <= '0;
      rpt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        sc_q[i] <= '0;
        hc_q[i] <= '0;
        rc_q[i] <= '0;
      end
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      ctr_q   <= ctr_d;
      tick_q  <= tick_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      for (int i = 0; i < N; i++) begin
        sc_q[i] <= sc_d[i];
        hc_q[i] <= hc_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  assign tick = tick_q;
  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign hold = hold_q;
  assign rpt  = rpt_q;

endmodule
